// File: rtl/bk_share_pkg.sv
// Shared types and defaults for the Brent-Kung adder share controller.
// Holds the arbiter state encoding and a constant-safe clog2.
package bk_share_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

   localparam int NREQ_DEF   = 4;
   localparam int NLAYER_DEF = 5;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/bk_adder.sv
// Brent-Kung parallel-prefix adder, N = 2**(nLayer-1) bits.
// out = {carry, sum} of inp_a + inp_b + inp_carry.
module bk_adder #(
   parameter int nLayer = 5,
   localparam int N = 2**(nLayer-1),
   localparam int L = nLayer-1
) (
   input  logic [N-1:0] inp_a,
   input  logic [N-1:0] inp_b,
   input  logic         inp_carry,
   output logic [N:0]   out
);

   logic [N-1:0] p;
   logic [N-1:0] g;
   logic [N-1:0] pp;
   logic [N-1:0] c;

   always_comb begin
      p = inp_a ^ inp_b;
      g = inp_a & inp_b;
      // fold carry-in into bit 0 so g[i] becomes the carry out of bit i
      g[0] = g[0] | (p[0] & inp_carry);
      pp = p;
      for (int l = 0; l < L; l++) begin
         for (int i = 0; i < N; i++) begin
            if (((i + 1) % (2 << l)) == 0) begin
               g[i]  = g[i] | (pp[i] & g[i - (1 << l)]);
               pp[i] = pp[i] & pp[i - (1 << l)];
            end
         end
      end
      for (int l = L - 2; l >= 0; l--) begin
         for (int i = 0; i < N; i++) begin
            if (i >= (2 << l) && ((i + 1) % (2 << l)) == (1 << l)) begin
               g[i] = g[i] | (pp[i] & g[i - (1 << l)]);
            end
         end
      end
      c[0] = inp_carry;
      for (int i = 1; i < N; i++) c[i] = g[i-1];
      out = {g[N-1], p ^ c};
   end

endmodule

// File: rtl/bk_adder_share_ctrl.sv
// Round-robin time-sharing of one Brent-Kung adder among NREQ requesters,
// with a chain lock that carries between beats of wide additions.
module bk_adder_share_ctrl
   import bk_share_pkg::*;
#(
   parameter int NLAYER = NLAYER_DEF,
   parameter int NREQ   = NREQ_DEF,
   parameter int IDW    = clog2(NREQ),
   localparam int N     = 2**(NLAYER-1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   input  logic [NREQ-1:0]   req_cin,
   input  logic [NREQ-1:0]   req_chain,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [N-1:0]      rsp_sum,
   output logic              rsp_cout,
   output logic              busy
);

   state_e         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] owner_q, owner_d;
   logic           carry_q, carry_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [N-1:0]   rsp_sum_q, rsp_sum_d;
   logic           rsp_cout_q, rsp_cout_d;

   logic [IDW-1:0] gid;
   logic [IDW-1:0] scan;
   logic           found;
   logic           free;
   logic           accept;
   logic           cin_sel;
   logic [N-1:0]   op_a, op_b;
   logic [N:0]     add_out;

   assign free = !rsp_valid_q | rsp_ready;

   always_comb begin
      found = 1'b0;
      gid   = '0;
      scan  = '0;
      if (state_q == LOCKED) begin
         found = req_valid[owner_q];
         gid   = owner_q;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            scan = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[scan]) begin
               found = 1'b1;
               gid   = scan;
            end
         end
      end
   end

   assign accept    = free & found & rst_n;
   assign req_ready = accept ? (NREQ'(1) << gid) : '0;
   assign op_a      = req_a[int'(gid)*N +: N];
   assign op_b      = req_b[int'(gid)*N +: N];
   assign cin_sel   = (state_q == LOCKED) ? carry_q : req_cin[gid];

   bk_adder #(
      .nLayer(NLAYER)
   ) u_add (
      .inp_a    (op_a),
      .inp_b    (op_b),
      .inp_carry(cin_sel),
      .out      (add_out)
   );

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      carry_d     = carry_q;
      rsp_valid_d = rsp_valid_q & ~rsp_ready;
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_id_d    = gid;
         rsp_sum_d   = add_out[N-1:0];
         rsp_cout_d  = add_out[N];
         if (req_chain[gid]) begin
            state_d = LOCKED;
            owner_d = gid;
            carry_d = add_out[N];
         end else begin
            state_d = IDLE;
            carry_d = 1'b0;
            ptr_d   = (int'(gid) == NREQ - 1) ? '0 : gid + IDW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         carry_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         carry_q     <= carry_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_cout  = rsp_cout_q;
   assign busy      = (state_q == LOCKED) | rsp_valid_q;

endmodule

// File: tb/tb_bk_adder_share_ctrl.sv
// Directed bench for bk_adder_share_ctrl: arbitration, chaining,
// backpressure, lock stall and asynchronous reset.
module tb_bk_adder_share_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_cin;
   logic [3:0]  req_chain;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_sum;
   logic        rsp_cout;
   logic        busy;

   int ntest = 0;
   int nfail = 0;

   bk_adder_share_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .req_cin  (req_cin),
      .req_chain(req_chain),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_id   (rsp_id),
      .rsp_sum  (rsp_sum),
      .rsp_cout (rsp_cout),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      ntest++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int i, input logic v, input logic [15:0] a,
                        input logic [15:0] b, input logic cin,
                        input logic chain);
      req_valid[i]       = v;
      req_a[i*16 +: 16]  = a;
      req_b[i*16 +: 16]  = b;
      req_cin[i]         = cin;
      req_chain[i]       = chain;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id,
                          input logic [15:0] s, input logic co);
      chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
      chk({tag, "_id"},    32'(rsp_id),    32'(id));
      chk({tag, "_sum"},   32'(rsp_sum),   32'(s));
      chk({tag, "_cout"},  32'(rsp_cout),  32'(co));
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      req_chain = '0;
      rsp_ready = 1'b1;
      #2;
      chk_rsp("reset0", 1'b0, 2'd0, 16'h0000, 1'b0);
      chk("reset0_busy",  32'(busy),      32'd0);
      chk("reset0_ready", 32'(req_ready), 32'd0);
      #10;
      rst_n = 1'b1;
      tick();

      // round robin: all four valid, ids 0,1,2,3,0
      for (int i = 0; i < 4; i++)
         drive(i, 1'b1, 16'(i), 16'h0100, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) begin
         #1;
         chk("rr_ready", 32'(req_ready), 32'(4'b0001 << (n % 4)));
         tick();
         chk_rsp("rr", 1'b1, 2'(n % 4), 16'h0100 + 16'(n % 4), 1'b0);
      end
      req_valid = '0;
      tick();
      chk("rr_drain", 32'(rsp_valid), 32'd0);

      // single beat on req1, ptr now at 1
      drive(1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      #1;
      chk("single_ready", 32'(req_ready), 32'b0010);
      tick();
      chk_rsp("single", 1'b1, 2'd1, 16'h0000, 1'b1);
      req_valid = '0;
      tick();
      chk("single_drain", 32'(rsp_valid), 32'd0);

      // 32-bit chained add on req2 with req0 competing, ptr at 2
      drive(0, 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0);
      drive(2, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
      #1;
      chk("chain1_ready", 32'(req_ready), 32'b0100);
      tick();
      chk_rsp("chain1", 1'b1, 2'd2, 16'h0000, 1'b1);
      chk("chain1_busy", 32'(busy), 32'd1);
      drive(2, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0);
      #1;
      chk("chain2_ready", 32'(req_ready), 32'b0100);
      tick();
      chk_rsp("chain2", 1'b1, 2'd2, 16'h0001, 1'b0);
      req_valid[2] = 1'b0;
      #1;
      chk("after_chain_ready", 32'(req_ready), 32'b0001);
      tick();
      chk_rsp("after_chain", 1'b1, 2'd0, 16'h000A, 1'b0);
      req_valid[0] = 1'b0;

      // backpressure: result 0x000A pending, req1 waiting
      rsp_ready = 1'b0;
      drive(1, 1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
      for (int n = 0; n < 3; n++) begin
         #1;
         chk("bp_ready", 32'(req_ready), 32'd0);
         chk_rsp("bp_hold", 1'b1, 2'd0, 16'h000A, 1'b0);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b0010);
      tick();
      chk_rsp("bp_reload", 1'b1, 2'd1, 16'h2345, 1'b0);
      req_valid[1] = 1'b0;
      tick();
      chk("bp_drain", 32'(rsp_valid), 32'd0);

      // owner stall inside a lock, ptr at 2
      drive(2, 1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
      #1;
      chk("stall_grant", 32'(req_ready), 32'b0100);
      tick();
      chk_rsp("stall_beat", 1'b1, 2'd2, 16'h0003, 1'b0);
      req_valid[2] = 1'b0;
      drive(1, 1'b1, 16'h0007, 16'h0000, 1'b0, 1'b0);
      for (int n = 0; n < 2; n++) begin
         #1;
         chk("stall_ready", 32'(req_ready), 32'd0);
         tick();
         chk("stall_busy", 32'(busy), 32'd1);
         chk("stall_valid", 32'(rsp_valid), 32'd0);
      end

      // asynchronous reset in the middle of the lock
      req_valid[0] = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk_rsp("arst", 1'b0, 2'd0, 16'h0000, 1'b0);
      chk("arst_busy",  32'(busy),      32'd0);
      chk("arst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", 32'(req_ready), 32'b0001);
      tick();
      chk_rsp("post_rst", 1'b1, 2'd0, 16'h000A, 1'b0);

      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end

endmodule
